// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and control-flow flush sequencer for the ID/EX
// boundary. Holds a stall for LOAD_STALL cycles per load-use hazard and a
// flush for FLUSH_LEN cycles per redirect. Interrupt requests that arrive
// during a stall or flush are latched and serviced once the pipeline is free.
// Optional statistics counters are built when HAZARD_CTRL_STATS_EN is defined.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STALL = 1,
  parameter int FLUSH_LEN  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ex_mem_read,
  input  logic [REG_ADDR_W-1:0]         ex_write_addr,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_valid,
  input  logic                          branch_taken,
  input  logic                          call,
  input  logic                          int_req,
  output logic                          stall,
  output logic                          flush,
  output logic                          int_ack,
  output logic                          busy
`ifdef HAZARD_CTRL_STATS_EN
  ,
  input  logic                          stats_clr,
  output logic [15:0]                   stall_cnt,
  output logic [15:0]                   flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Counter reload values; the first stall/flush cycle is spent in RUN, so
  // the extra cycles held in STALL/FLUSH number LEN-1, counted down to zero.
  localparam logic [3:0] STALL_RELOAD = (LOAD_STALL > 1) ? 4'(LOAD_STALL - 2) : 4'd0;
  localparam logic [3:0] FLUSH_RELOAD = (FLUSH_LEN > 1)  ? 4'(FLUSH_LEN - 2)  : 4'd0;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       int_pend, int_pend_nxt;
  logic       src_match;
  logic       hazard;
  logic       br_call;

  // Compare every qualified ID source operand against the EX destination
  always_comb begin
    src_match = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (id_src_valid[i] && (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W] == ex_write_addr))
        src_match = 1'b1;
    end
  end

  assign hazard  = ex_mem_read & src_match;
  assign br_call = branch_taken | call;
  assign busy    = (state != RUN);

  // Next-state, counter, pending-interrupt and output decode
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    int_pend_nxt = int_pend;
    stall        = 1'b0;
    flush        = 1'b0;
    int_ack      = 1'b0;
    case (state)
      RUN: begin
        if (hazard) begin
          // Hazard beats redirect; a concurrent branch/call is re-presented
          // by the pipeline after the bubble, an interrupt is kept pending.
          stall        = 1'b1;
          int_pend_nxt = int_pend | int_req;
          if (LOAD_STALL > 1) begin
            state_nxt = STALL;
            cnt_nxt   = STALL_RELOAD;
          end
        end else if (br_call) begin
          // Branch/call wins over an interrupt in the same cycle; the
          // interrupt is taken on a later free RUN cycle.
          flush        = 1'b1;
          int_pend_nxt = int_pend | int_req;
          if (FLUSH_LEN > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = FLUSH_RELOAD;
          end
        end else if (int_pend || int_req) begin
          flush        = 1'b1;
          int_ack      = 1'b1;
          int_pend_nxt = 1'b0;
          if (FLUSH_LEN > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = FLUSH_RELOAD;
          end
        end
      end
      STALL: begin
        stall        = 1'b1;
        int_pend_nxt = int_pend | int_req;
        if (cnt == 4'd0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      FLUSH: begin
        flush        = 1'b1;
        int_pend_nxt = int_pend | int_req;
        if (br_call) begin
          if (FLUSH_LEN > 1) begin
            cnt_nxt = FLUSH_RELOAD;
          end else begin
            state_nxt = RUN;
          end
        end else if (cnt == 4'd0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, countdown and interrupt-pending registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      int_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      int_pend <= int_pend_nxt;
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  // Saturating stall/flush cycle counters, clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Three instances with different
// latency parameters share one input bus; each check targets the instance whose
// parameters the scenario needs. Outputs are compared as {stall,flush,int_ack,busy}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mr;
  logic [2:0] wa;
  logic [5:0] sa;
  logic [1:0] sv;
  logic       br, cl, ir;

  logic s1, f1, a1, b1;
  logic s2, f2, a2, b2;
  logic s3, f3, a3, b3;
  logic [3:0] o1, o2, o3;

  int passed = 0;
  int total  = 0;

`ifdef HAZARD_CTRL_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] sc1, fc1, sc2, fc2, sc3, fc3;
`endif

  always #5 clk = ~clk;

  assign o1 = {s1, f1, a1, b1};
  assign o2 = {s2, f2, a2, b2};
  assign o3 = {s3, f3, a3, b3};

  hazard_ctrl #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_STALL(1), .FLUSH_LEN(1)) u1 (
    .clk(clk), .rst(rst), .ex_mem_read(mr), .ex_write_addr(wa),
    .id_src_addr(sa), .id_src_valid(sv), .branch_taken(br), .call(cl),
    .int_req(ir), .stall(s1), .flush(f1), .int_ack(a1), .busy(b1)
`ifdef HAZARD_CTRL_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );

  hazard_ctrl #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_STALL(2), .FLUSH_LEN(4)) u2 (
    .clk(clk), .rst(rst), .ex_mem_read(mr), .ex_write_addr(wa),
    .id_src_addr(sa), .id_src_valid(sv), .branch_taken(br), .call(cl),
    .int_req(ir), .stall(s2), .flush(f2), .int_ack(a2), .busy(b2)
`ifdef HAZARD_CTRL_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(sc2), .flush_cnt(fc2)
`endif
  );

  hazard_ctrl #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_STALL(3), .FLUSH_LEN(2)) u3 (
    .clk(clk), .rst(rst), .ex_mem_read(mr), .ex_write_addr(wa),
    .id_src_addr(sa), .id_src_valid(sv), .branch_taken(br), .call(cl),
    .int_req(ir), .stall(s3), .flush(f3), .int_ack(a3), .busy(b3)
`ifdef HAZARD_CTRL_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );

  typedef struct {
    logic       mr;
    logic [2:0] wa;
    logic [5:0] sa;
    logic [1:0] sv;
    logic       br;
    logic       cl;
    logic       ir;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Apply one cycle of inputs at the falling edge, then let outputs settle
  task automatic cyc(input logic m, input logic [2:0] w, input logic [5:0] s,
                     input logic [1:0] v, input logic b, input logic c, input logic i);
    @(negedge clk);
    mr = m; wa = w; sa = s; sv = v; br = b; cl = c; ir = i;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 6'o00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mr = 1'b0; wa = '0; sa = '0; sv = '0; br = 1'b0; cl = 1'b0; ir = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // sa = {op1, op0} written in octal, one digit per operand
    tbl[0]  = '{1'b1, 3'd3, 6'o30, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1000};
    tbl[1]  = '{1'b1, 3'd3, 6'o30, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[2]  = '{1'b1, 3'd5, 6'o05, 2'b01, 1'b0, 1'b0, 1'b0, 4'b1000};
    tbl[3]  = '{1'b0, 3'd5, 6'o05, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[4]  = '{1'b1, 3'd2, 6'o14, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{1'b0, 3'd0, 6'o00, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0100};
    tbl[6]  = '{1'b0, 3'd0, 6'o00, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0100};
    tbl[7]  = '{1'b0, 3'd0, 6'o00, 2'b00, 1'b0, 1'b0, 1'b1, 4'b0110};
    tbl[8]  = '{1'b0, 3'd0, 6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[9]  = '{1'b1, 3'd3, 6'o03, 2'b01, 1'b1, 1'b0, 1'b0, 4'b1000};
    tbl[10] = '{1'b1, 3'd3, 6'o03, 2'b01, 1'b0, 1'b0, 1'b1, 4'b1000};
    tbl[11] = '{1'b0, 3'd0, 6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0110};
    tbl[12] = '{1'b0, 3'd0, 6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[13] = '{1'b0, 3'd0, 6'o00, 2'b00, 1'b1, 1'b0, 1'b1, 4'b0100};
    tbl[14] = '{1'b0, 3'd0, 6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0110};
    tbl[15] = '{1'b0, 3'd0, 6'o00, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[16] = '{1'b1, 3'd0, 6'o07, 2'b10, 1'b0, 1'b0, 1'b0, 4'b1000};
    tbl[17] = '{1'b1, 3'd7, 6'o77, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000};

    // Reset state of all instances
    do_reset();
    chk("reset_u1", 16'(o1), 16'h0);
    chk("reset_u2", 16'(o2), 16'h0);
    chk("reset_u3", 16'(o3), 16'h0);

    // Single-cycle latencies: every row is one cycle on u1
    for (int k = 0; k < 18; k++) begin
      cyc(tbl[k].mr, tbl[k].wa, tbl[k].sa, tbl[k].sv, tbl[k].br, tbl[k].cl, tbl[k].ir);
      chk($sformatf("vec%0d", k), 16'(o1), 16'(tbl[k].exp));
    end

    // LOAD_STALL=3: three stall cycles, busy on the last two
    do_reset();
    cyc(1'b1, 3'd3, 6'o30, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("ls3_t0", 16'(o3), 16'h8);
    idle(); chk("ls3_t1", 16'(o3), 16'h9);
    idle(); chk("ls3_t2", 16'(o3), 16'h9);
    idle(); chk("ls3_t3", 16'(o3), 16'h0);

    // FLUSH_LEN=2: single pulse, then a re-armed flush
    do_reset();
    cyc(1'b0, 3'd0, 6'o00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("fl2_t0", 16'(o3), 16'h4);
    idle(); chk("fl2_t1", 16'(o3), 16'h5);
    idle(); chk("fl2_t2", 16'(o3), 16'h0);
    cyc(1'b0, 3'd0, 6'o00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("fl2x_t0", 16'(o3), 16'h4);
    cyc(1'b0, 3'd0, 6'o00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("fl2x_t1", 16'(o3), 16'h5);
    idle(); chk("fl2x_t2", 16'(o3), 16'h5);
    idle(); chk("fl2x_t3", 16'(o3), 16'h0);

    // Branch during STALL is ignored
    do_reset();
    cyc(1'b1, 3'd3, 6'o03, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("stbr_t0", 16'(o3), 16'h8);
    cyc(1'b0, 3'd0, 6'o00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("stbr_t1", 16'(o3), 16'h9);
    idle(); chk("stbr_t2", 16'(o3), 16'h9);
    idle(); chk("stbr_t3", 16'(o3), 16'h0);

    // Interrupt during FLUSH waits for the flush to end
    do_reset();
    cyc(1'b0, 3'd0, 6'o00, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("flint_t0", 16'(o3), 16'h4);
    cyc(1'b0, 3'd0, 6'o00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("flint_t1", 16'(o3), 16'h5);
    idle(); chk("flint_t2", 16'(o3), 16'h6);
    idle(); chk("flint_t3", 16'(o3), 16'h5);
    idle(); chk("flint_t4", 16'(o3), 16'h0);

    // LOAD_STALL=2 with interrupt latched in STALL; then a 4-cycle flush
    do_reset();
    cyc(1'b1, 3'd3, 6'o30, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("stint_t0", 16'(o2), 16'h8);
    cyc(1'b0, 3'd0, 6'o00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("stint_t1", 16'(o2), 16'h9);
    idle(); chk("stint_t2", 16'(o2), 16'h6);
    idle(); chk("stint_t3", 16'(o2), 16'h5);
    idle(); chk("stint_t4", 16'(o2), 16'h5);
    idle(); chk("stint_t5", 16'(o2), 16'h5);
    idle(); chk("stint_t6", 16'(o2), 16'h0);

    // Reset mid-flush aborts it and discards a pending interrupt
    do_reset();
    cyc(1'b0, 3'd0, 6'o00, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("rstfl_t0", 16'(o2), 16'h4);
    idle(); chk("rstfl_t1", 16'(o2), 16'h5);
    do_reset();
    chk("rstfl_after", 16'(o2), 16'h0);
    idle(); chk("rstfl_nopend", 16'(o2), 16'h0);

`ifdef HAZARD_CTRL_STATS_EN
    // Three LOAD_STALL=2 stalls on u2 give six stall cycles
    do_reset();
    for (int n = 0; n < 3; n++) begin
      cyc(1'b1, 3'd3, 6'o30, 2'b11, 1'b0, 1'b0, 1'b0);
      idle();
    end
    idle();
    chk("stats_six", sc2, 16'd6);
    @(negedge clk); stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0;
    #1;
    chk("stats_clr", sc2, 16'd0);
    cyc(1'b1, 3'd3, 6'o30, 2'b11, 1'b0, 1'b0, 1'b0);
    repeat (70000) @(negedge clk);
    #1;
    chk("stats_sat", sc2, 16'hFFFF);
    idle();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised, stateful successor to the pipeline's hazard detection unit. Sits beside the ID/EX pipeline registers.
- Detects load-use hazards across N source operands and holds the stall for a configurable number of load-latency cycles.
- Flushes the front end for a configurable number of cycles on any control-flow redirect (jmp, call/ret/rti, interrupt).
- Latches interrupt requests that arrive while a stall or flush is in progress, services them afterwards, and acknowledges them.

Parameters:
- REG_ADDR_W, 3, register address width.
- NUM_SRC, 2, number of ID-stage source operands compared (1..4).
- LOAD_STALL, 1, stall cycles per load-use hazard (1..15).
- FLUSH_LEN, 1, flush cycles per redirect (1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_write_addr  in  REG_ADDR_W  destination register of the EX instruction.
- id_src_addr  in  NUM_SRC*REG_ADDR_W  ID source addresses; operand i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
- id_src_valid  in  NUM_SRC  per-operand "really read" qualifier.
- branch_taken  in  1  jmp/conditional branch resolved taken.
- call  in  1  call/ret/rti redirect.
- int_req  in  1  interrupt request, level; edge not required.
- stall  out  1  freeze PC and IF/ID; insert bubble into EX.
- flush  out  1  clear IF/ID and ID/EX.
- int_ack  out  1  one-cycle pulse: the interrupt redirect is being taken.
- busy  out  1  state != RUN.

Behaviour:
- Reset: state=RUN, cnt=0, int_pend=0. stall, flush, int_ack and busy are all 0 in the cycle after rst is sampled high. rst mid-stall or mid-flush aborts immediately. A pending interrupt is discarded.
- hazard = ex_mem_read & OR over i of (id_src_valid[i] & id_src_addr[i]==ex_write_addr).
- redirect = branch_taken | call | int_pend | int_req.
- State RUN, evaluated combinationally in the same cycle:
  - hazard: stall=1, flush=0. If LOAD_STALL>1, next state=STALL with cnt=LOAD_STALL-2. Hazard has priority over redirect, as in the legacy unit. A concurrent int_req is latched into int_pend. A concurrent branch_taken/call is dropped; the pipeline guarantees it re-presents after the bubble.
  - else redirect: flush=1, stall=0. If the cause is an interrupt and not branch/call, int_ack=1 and int_pend clears. If FLUSH_LEN>1, next state=FLUSH with cnt=FLUSH_LEN-2.
  - else: all outputs 0.
- State STALL:
  - stall=1, flush=0. Inputs ex_*/id_* are ignored.
  - int_req sets int_pend.
  - branch_taken/call are illegal here and are ignored.
  - cnt==0: return to RUN; else cnt-1.
- State FLUSH:
  - flush=1, stall=0. The hazard check is suppressed because the flushed instructions are invalid.
  - int_req sets int_pend. It is serviced only after FLUSH ends and not merged into the current flush.
  - branch_taken/call re-arm cnt=FLUSH_LEN-2, or return to RUN if FLUSH_LEN==1.
  - cnt==0: return to RUN.
- branch/call and interrupt in the same RUN cycle: flush for the branch; the interrupt stays or becomes pending, int_ack=0. The interrupt is taken on the next RUN cycle with no hazard.
- int_ack never asserts while stall=1. int_ack asserts at most once per int_pend set.
- stall and flush are never both 1.
- Counter width is 4 bits; no wrap occurs within the legal parameter range.

Optional Feature:
- Macro: HAZARD_CTRL_STATS_EN.
- When defined:
  - Adds outputs stall_cnt[15:0] and flush_cnt[15:0]. Each increments on every cycle its respective output is 1 and saturates at 16'hFFFF.
  - Adds input stats_clr, which zeroes both counters synchronously; stats_clr has priority over increment.
  - rst zeroes both counters.
- When undefined: these ports and registers do not exist, and core behaviour is identical.

Test Plan:
- LOAD_STALL=1. ex_mem_read=1, ex_write_addr=3, id_src_addr op1=3, valid=2'b11 → stall=1 for exactly 1 cycle, flush=0, busy=0. With valid[1]=0 and the match on op1 → stall=0.
- LOAD_STALL=3. Hazard at cycle t, inputs removed at t+1 → stall=1 at t, t+1, t+2; 0 at t+3; busy=1 at t+1..t+2.
- FLUSH_LEN=2. branch_taken pulse at t → flush=1 at t, t+1. Second branch_taken at t+1 → flush extends through t+2.
- LOAD_STALL=2. int_req pulses for 1 cycle during the STALL cycle → int_pend latched. Stall ends at t+1; at t+2 flush=1 and int_ack=1 for 1 cycle.
- Hazard and branch_taken in the same cycle → stall=1, flush=0. Assert rst during a FLUSH_LEN=4 flush → next cycle all outputs 0 and int_pend=0.
- With HAZARD_CTRL_STATS_EN defined: 3 stalls of LOAD_STALL=2 → stall_cnt=6. Pulse stats_clr → stall_cnt=0. Force 70000 stall cycles → stall_cnt=16'hFFFF.
